// File: rtl/fetch_sequencer_if.sv
// Instruction-memory request/acknowledge bus between the fetch
// sequencer (master) and the instruction memory (slave).
interface fetch_sequencer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req;
  logic [ADDR_W-1:0] addr;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req,
    output addr,
    input  ack,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output ack,
    output rdata
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch control: drives the PC loop, runs the imem handshake,
// holds words under stall, defers redirects and traps timeouts.
module fetch_sequencer #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] pc,
  input  logic              stall,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  fetch_sequencer_if.master imem,
  output logic              pc_en,
  output logic              pc_branch_sel,
  output logic [ADDR_W-1:0] pc_branch_addr,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic              flush,
  output logic              timeout_err
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] REQ  = 3'd1;
  localparam logic [2:0] WAIT = 3'd2;
  localparam logic [2:0] HOLD = 3'd3;
  localparam logic [2:0] ADV  = 3'd4;
  localparam logic [2:0] ERR  = 3'd5;

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_WAIT - 1);

  logic [2:0]        state_q, state_d;
  logic              br_pending_q, br_pending_d;
  logic [ADDR_W-1:0] tgt_q, tgt_d;
  logic [CW-1:0]     wait_cnt_q, wait_cnt_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic              in_fetch;
  logic              redirect;

  assign in_fetch = (state_q == REQ) || (state_q == WAIT);
  assign redirect = br_pending_q || br_taken;

  always_comb begin
    state_d      = state_q;
    br_pending_d = br_pending_q;
    tgt_d        = tgt_q;
    wait_cnt_d   = wait_cnt_q;
    instr_d      = instr_q;
    // a later branch overwrites an earlier deferred target
    if (br_taken && (in_fetch || state_q == HOLD)) begin
      br_pending_d = 1'b1;
      tgt_d        = br_target;
    end
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = REQ;
          wait_cnt_d = '0;
        end
      end
      REQ, WAIT: begin
        if (imem.ack) begin
          instr_d = imem.rdata;
          if (redirect)   state_d = ADV;
          else if (stall) state_d = HOLD;
          else            state_d = ADV;
        end else if (wait_cnt_q == CNT_LAST) begin
          state_d = ERR;
        end else begin
          state_d    = WAIT;
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (br_taken || !stall) state_d = ADV;
      end
      ADV: begin
        state_d      = REQ;
        wait_cnt_d   = '0;
        br_pending_d = 1'b0;
      end
      ERR: begin
        state_d = ERR;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      br_pending_q <= 1'b0;
      tgt_q        <= '0;
      wait_cnt_q   <= '0;
      instr_q      <= '0;
    end else begin
      state_q      <= state_d;
      br_pending_q <= br_pending_d;
      tgt_q        <= tgt_d;
      wait_cnt_q   <= wait_cnt_d;
      instr_q      <= instr_d;
    end
  end

  always_comb begin
    imem.req       = 1'b0;
    imem.addr      = '0;
    pc_en          = 1'b0;
    pc_branch_sel  = 1'b0;
    pc_branch_addr = '0;
    instr_valid    = 1'b0;
    flush          = 1'b0;
    timeout_err    = 1'b0;
    unique case (state_q)
      REQ, WAIT: begin
        imem.req  = 1'b1;
        imem.addr = pc;
      end
      HOLD: begin
        instr_valid = 1'b1;
      end
      ADV: begin
        pc_en         = 1'b1;
        pc_branch_sel = redirect;
        flush         = redirect;
        instr_valid   = !redirect;
        if (redirect)
          pc_branch_addr = br_taken ? br_target : tgt_q;
      end
      ERR: begin
        timeout_err = 1'b1;
      end
      default: ;
    endcase
  end

  assign instr = instr_q;

endmodule
